matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
- Sequencer for one 8x8 systolic matmul pass plus its output-shift stage.
- Accepts a start/done handshake from the host.
- Drives matmul_op_in_progress, clk_cnt and done_mat_mul into the output logic.
- Tracks the c_data_available row stream and generates write enable and address for the C result buffer, one row per beat.

Parameters:
- MAT_MUL_SIZE, 8, rows (beats) shifted out per pass.
- LATCH_CYCLE, 27, clk_cnt value at which the output logic latches C.
- AWIDTH, 10, C-buffer address width.
- TIMEOUT_CYCLE, 255, clk_cnt value that aborts a hung pass.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  host request; single-cycle pulse, sampled only in IDLE.
- abort  in  1  host abort; honoured in any state.
- c_addr_base  in  AWIDTH  C-buffer base address; captured on accepted start.
- c_data_available  in  1  row-valid from the output logic.
- matmul_op_in_progress  out  1  enables PEs and output logic.
- clk_cnt  out  8  cycle counter since start.
- done_mat_mul  out  1  one-cycle end-of-pass pulse to the output logic.
- c_we  out  1  C-buffer write enable.
- c_addr  out  AWIDTH  C-buffer write address.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse to the host.
- timeout_err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset values:
  - Every output is 0.
  - State = IDLE; row_cnt = 0; base_q = 0.
- States: IDLE, COMPUTE, DRAIN, FINISH.
- IDLE:
  - start=1 and abort=0 → COMPUTE next cycle.
  - On that transition: capture base_q <= c_addr_base, clk_cnt <= 0, timeout_err <= 0.
- COMPUTE:
  - matmul_op_in_progress=1.
  - clk_cnt increments by 1 each cycle and saturates at 255.
  - First cycle with c_data_available=1 → DRAIN. That cycle counts as beat 0.
- DRAIN:
  - matmul_op_in_progress=1; clk_cnt keeps counting.
  - The row_cnt == MAT_MUL_SIZE-1 beat → FINISH.
- Beat rule (COMPUTE or DRAIN):
  - c_we = c_data_available & (row_cnt < MAT_MUL_SIZE), combinational.
  - c_addr = base_q + row_cnt, AWIDTH-bit and wrapping modulo 2^AWIDTH.
  - row_cnt increments on each beat.
  - Exactly MAT_MUL_SIZE writes per pass, on consecutive cycles.
  - Further c_data_available cycles produce no writes.
- FINISH (exactly 1 cycle):
  - done_mat_mul=1 and done=1.
  - matmul_op_in_progress stays 1 so the output logic sees done_mat_mul.
  - Next state IDLE; row_cnt and clk_cnt cleared.
- Timeout:
  - In COMPUTE or DRAIN, clk_cnt == TIMEOUT_CYCLE → timeout_err <= 1, then FINISH.
  - No c_we on that cycle.
- Abort:
  - Any non-IDLE state → IDLE next cycle, with no done pulse.
  - matmul_op_in_progress drops next cycle; c_we is forced to 0 in the abort cycle.
- Simultaneous events:
  - abort and start together in IDLE: abort wins, start dropped.
  - start while busy=1: ignored, not queued.
  - Timeout and last beat in the same cycle: last beat wins (write issued, no error).
- Reset mid-operation: asynchronously returns to IDLE with all outputs 0. No done pulse.
- Nominal latency: start accepted at cycle T; first beat at T+LATCH_CYCLE+2; done at T+LATCH_CYCLE+MAT_MUL_SIZE+2.

Optional Feature:
- Macro: MATMUL_SEQ_PERF_CNT_EN.
- With it:
  - Adds output perf_cycles [31:0]: cycles from accepted start to FINISH inclusive. Valid from FINISH until the next accepted start; reset 0.
  - Adds output perf_passes [15:0]: count of completed non-aborted passes, wrapping at 16 bits.
- Without it: neither port nor its counters exist. All other behaviour is identical.

Decomposition:
- Shared package matmul_seq_pkg holds:
  - state enum;
  - MAT_MUL_SIZE, LATCH_CYCLE and TIMEOUT_CYCLE defaults;
  - CLK_CNT_W=8.
- One natural sub-module, matmul_seq_addr_gen: base_q/row_cnt register plus address adder and beat-limit compare.
- FSM, clk_cnt, timeout and perf logic stay in the top module.

Test Plan:
- Nominal pass: start with c_addr_base=0x100, model asserts c_data_available from clk_cnt=28 → c_we on 8 consecutive cycles at addresses 0x100..0x107; done and done_mat_mul pulse once on the cycle after 0x107; busy returns to 0.
- Address wrap: c_addr_base=0x3FC, AWIDTH=10 → writes to 0x3FC,0x3FD,0x3FE,0x3FF,0x000..0x003.
- Extended available: c_data_available held high for 12 cycles → exactly 8 writes; no c_we afterwards.
- Timeout: c_data_available never asserted → clk_cnt reaches 255, timeout_err=1, done pulses, zero writes; next start clears timeout_err.
- Abort at beat 3: abort asserted on the cycle of the fourth write → that write is suppressed; busy=0 the next cycle; no done; the following pass completes normally from a fresh base.
- Async reset mid-DRAIN plus start-while-busy: reset=0 for 1 cycle → outputs 0 immediately; a start pulse issued during COMPUTE is ignored, with only one done observed.

Source files
------------

// File: rtl/matmul_seq_pkg.sv
// rtl/matmul_seq_pkg.sv - shared types and default sizes for the matmul pass sequencer
// Contents:
//   state_t        sequencer states IDLE/COMPUTE/DRAIN/FINISH
//   MAT_MUL_SIZE   rows shifted out per pass
//   LATCH_CYCLE    clk_cnt value at which the output logic latches C
//   TIMEOUT_CYCLE  clk_cnt value that aborts a hung pass
//   AWIDTH         default C-buffer address width
//   CLK_CNT_W      width of the cycle counter
package matmul_seq_pkg;

    localparam int MAT_MUL_SIZE  = 8;
    localparam int LATCH_CYCLE   = 27;
    localparam int TIMEOUT_CYCLE = 255;
    localparam int AWIDTH        = 10;
    localparam int CLK_CNT_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DRAIN   = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

endpackage

// File: rtl/matmul_seq_addr_gen.sv
// rtl/matmul_seq_addr_gen.sv - C-buffer row address generator and beat limiter
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   load         accepted start: capture base, clear row count
//   clear        end of pass (finish or abort): clear row count
//   beat         a row was written this cycle: advance row count
//   base         C-buffer base address to capture on load
//   addr         base_q + row_cnt, wrapping modulo 2^AWIDTH
//   room         row_cnt < MAT_MUL_SIZE (more rows may still be written)
//   last         row_cnt == MAT_MUL_SIZE-1 (current beat is the final row)
module matmul_seq_addr_gen #(
    parameter int AWIDTH       = 10,
    parameter int MAT_MUL_SIZE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              beat,
    input  logic [AWIDTH-1:0] base,
    output logic [AWIDTH-1:0] addr,
    output logic              room,
    output logic              last
);

    // One extra bit so the count can represent MAT_MUL_SIZE itself.
    localparam int RW = $clog2(MAT_MUL_SIZE + 1);

    logic [RW-1:0]     row_cnt;
    logic [AWIDTH-1:0] base_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q  <= '0;
            row_cnt <= '0;
        end else if (load) begin
            base_q  <= base;
            row_cnt <= '0;
        end else if (clear) begin
            row_cnt <= '0;
        end else if (beat) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    assign addr = base_q + AWIDTH'(row_cnt);
    assign room = (row_cnt < RW'(MAT_MUL_SIZE));
    assign last = (row_cnt == RW'(MAT_MUL_SIZE - 1));

endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - sequencer for one 8x8 systolic matmul pass and its C row write-out
// Optional feature macro: MATMUL_SEQ_PERF_CNT_EN (adds perf_cycles / perf_passes).
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   start                  host request pulse, sampled only in IDLE
//   abort                  host abort, honoured in any state
//   c_addr_base            C-buffer base address, captured on accepted start
//   c_data_available       row-valid from the output logic
//   matmul_op_in_progress  enables PEs and output logic
//   clk_cnt                cycle counter since start, saturating
//   done_mat_mul           one-cycle end-of-pass pulse to the output logic
//   c_we, c_addr           C-buffer write enable and address, one row per beat
//   busy                   high in any state other than IDLE
//   done                   one-cycle completion pulse to the host
//   timeout_err            sticky error, cleared by the next accepted start
//   perf_cycles            (macro) cycles from accepted start to FINISH inclusive
//   perf_passes            (macro) completed non-aborted passes, wrapping
module matmul_seq_ctrl
    import matmul_seq_pkg::*;
#(
    parameter int AWIDTH = matmul_seq_pkg::AWIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AWIDTH-1:0]    c_addr_base,
    input  logic                 c_data_available,
    output logic                 matmul_op_in_progress,
    output logic [CLK_CNT_W-1:0] clk_cnt,
    output logic                 done_mat_mul,
    output logic                 c_we,
    output logic [AWIDTH-1:0]    c_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
`ifdef MATMUL_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [15:0]          perf_passes
`endif
);

    state_t state;

    logic active;
    logic accept;
    logic timeout_hit;
    logic room;
    logic last;
    logic beat;
    logic finish_now;

    assign active      = (state == S_COMPUTE) || (state == S_DRAIN);
    assign accept      = (state == S_IDLE) && start && !abort;
    assign timeout_hit = active && (clk_cnt == CLK_CNT_W'(TIMEOUT_CYCLE));

    // A beat on the timeout cycle is only allowed if it is the final row;
    // the final row takes priority over the timeout.
    assign beat = active && !abort && c_data_available && room
                  && (!timeout_hit || last);
    assign c_we = beat;

    assign finish_now = active && !abort && ((beat && last) || timeout_hit);

    matmul_seq_addr_gen #(
        .AWIDTH       (AWIDTH),
        .MAT_MUL_SIZE (MAT_MUL_SIZE)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .clear ((state == S_FINISH) || abort),
        .beat  (beat),
        .base  (c_addr_base),
        .addr  (c_addr),
        .room  (room),
        .last  (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= S_IDLE;
            matmul_op_in_progress <= 1'b0;
            clk_cnt               <= '0;
            done_mat_mul          <= 1'b0;
            done                  <= 1'b0;
            busy                  <= 1'b0;
            timeout_err           <= 1'b0;
        end else begin
            done         <= 1'b0;
            done_mat_mul <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state                 <= S_COMPUTE;
                        matmul_op_in_progress <= 1'b1;
                        busy                  <= 1'b1;
                        clk_cnt               <= '0;
                        timeout_err           <= 1'b0;
                    end
                end
                S_COMPUTE, S_DRAIN: begin
                    if (abort) begin
                        state                 <= S_IDLE;
                        matmul_op_in_progress <= 1'b0;
                        busy                  <= 1'b0;
                        clk_cnt               <= '0;
                    end else begin
                        if (clk_cnt != {CLK_CNT_W{1'b1}}) begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                        if (finish_now) begin
                            state        <= S_FINISH;
                            done         <= 1'b1;
                            done_mat_mul <= 1'b1;
                            if (!(beat && last)) begin
                                timeout_err <= 1'b1;
                            end
                        end else if (beat) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_FINISH: begin
                    state                 <= S_IDLE;
                    matmul_op_in_progress <= 1'b0;
                    busy                  <= 1'b0;
                    clk_cnt               <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MATMUL_SEQ_PERF_CNT_EN
    // perf_cycles starts at 2 on entry to COMPUTE: the start cycle and the
    // first COMPUTE cycle are both already elapsed when it is first visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
            perf_passes <= '0;
        end else begin
            if (accept) begin
                perf_cycles <= 32'd2;
            end else if (active && !abort) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (finish_now) begin
                perf_passes <= perf_passes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - scoreboard bench for matmul_seq_ctrl
module tb_matmul_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] c_addr_base = '0;
    logic       c_data_available = 1'b0;
    logic       matmul_op_in_progress;
    logic [7:0] clk_cnt;
    logic       done_mat_mul;
    logic       c_we;
    logic [9:0] c_addr;
    logic       busy;
    logic       done;
    logic       timeout_err;

    matmul_seq_ctrl #(.AWIDTH(10)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .abort                 (abort),
        .c_addr_base           (c_addr_base),
        .c_data_available      (c_data_available),
        .matmul_op_in_progress (matmul_op_in_progress),
        .clk_cnt               (clk_cnt),
        .done_mat_mul          (done_mat_mul),
        .c_we                  (c_we),
        .c_addr                (c_addr),
        .busy                  (busy),
        .done                  (done),
        .timeout_err           (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] addr;
        int         cyc;
        int         cnt;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected writes and done pulses as the DUT presents them.
    always @(negedge clk) begin
        if (reset) begin
            if (c_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("c_addr", c_addr, w.addr);
                    chk("write_cycle", cyc, w.cyc);
                    chk("write_clk_cnt", clk_cnt, w.cnt);
                end
            end
            if (done || done_mat_mul) begin
                chk("done_mat_mul_eq_done", done_mat_mul, done);
                chk("op_during_done", matmul_op_in_progress, 1);
                if (dq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_cycle", cyc, dq.pop_front());
                end
            end
        end
    end

    // Reference: rows go out on the first available cycles of the window, at
    // most 8, unless clk_cnt reaches 255 first (the 8th row may still land on
    // 255). Without all 8 rows the pass ends by timeout, FINISH at offset 257.
    task automatic run_pass(input logic [9:0] base, input int s, input int len,
                            input int kill_beat, input bit kill_rst, input int busy_start_k);
        int  t0, n_w, done_k, kill_k, end_k;
        bit  tmo, killed;
        wr_t w;
        n_w = 0; tmo = 0; killed = 0;
        for (int i = 0; i < 8; i++) begin
            if (kill_beat == i) begin killed = 1; break; end
            if (i >= len || s + i > 255 || (s + i == 255 && i != 7)) begin tmo = 1; break; end
            n_w++;
        end
        done_k = tmo ? 257 : s + 9;
        kill_k = 1 + s + kill_beat;
        end_k  = killed ? kill_k + 1 : done_k + 2;
        if (!killed && s < 256 && s + len + 1 > end_k) end_k = s + len + 1;

        step();
        start = 1'b1;
        c_addr_base = base;
        t0 = cyc;
        for (int i = 0; i < n_w; i++) begin
            w.addr = base + 10'(i);
            w.cyc  = t0 + 1 + s + i;
            w.cnt  = s + i;
            wq.push_back(w);
        end
        if (!killed) dq.push_back(t0 + done_k);

        for (int k = 1; k <= end_k; k++) begin
            step();
            start = (k == busy_start_k);
            abort = 1'b0;
            c_data_available = (k - 1 >= s) && (k - 1 < s + len);
            if (k == 1) begin
                chk("busy_after_start", busy, 1);
                chk("clk_cnt_first", clk_cnt, 0);
                chk("timeout_err_cleared", timeout_err, 0);
                chk("op_after_start", matmul_op_in_progress, 1);
            end
            if (killed && k == kill_k) begin
                if (kill_rst) begin
                    reset = 1'b0;
                    #1;
                    chk("rst_c_we", c_we, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_op", matmul_op_in_progress, 0);
                    chk("rst_clk_cnt", clk_cnt, 0);
                    chk("rst_c_addr", c_addr, 0);
                    chk("rst_done", done, 0);
                end else begin
                    abort = 1'b1;
                end
            end
            if (killed && k == kill_k + 1) begin
                reset = 1'b1;
                chk("busy_after_kill", busy, 0);
                chk("op_after_kill", matmul_op_in_progress, 0);
            end
        end
        step();
        start = 1'b0;
        abort = 1'b0;
        c_data_available = 1'b0;
        chk("busy_end", busy, 0);
        chk("timeout_err_end", timeout_err, (tmo && !killed) ? 1 : 0);
    endtask

    initial begin
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_c_we", c_we, 0);
        chk("reset_done", done, 0);
        chk("reset_clk_cnt", clk_cnt, 0);
        chk("reset_c_addr", c_addr, 0);
        chk("reset_op", matmul_op_in_progress, 0);
        reset = 1'b1;
        step();

        // abort and start together in IDLE: start dropped
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_wins_busy", busy, 0);
        step();
        chk("abort_wins_busy2", busy, 0);

        run_pass(10'h100, 28, 8, -1, 1'b0, 0);   // nominal
        run_pass(10'h3FC, 28, 8, -1, 1'b0, 0);   // address wrap
        run_pass(10'h040, 28, 12, -1, 1'b0, 0);  // extended available
        run_pass(10'h080, 300, 0, -1, 1'b0, 0);  // timeout, no rows
        run_pass(10'h200, 28, 8, -1, 1'b0, 0);   // clears timeout_err
        run_pass(10'h150, 28, 8, 3, 1'b0, 0);    // abort at beat 3
        run_pass(10'h2A0, 28, 8, -1, 1'b0, 0);   // fresh pass after abort
        run_pass(10'h010, 28, 8, 5, 1'b1, 5);    // start while busy, reset mid-DRAIN
        run_pass(10'h020, 28, 8, -1, 1'b0, 0);
        run_pass(10'h300, 248, 8, -1, 1'b0, 0);  // last beat on timeout cycle
        run_pass(10'h310, 249, 8, -1, 1'b0, 0);  // timeout before last beat

        for (int r = 0; r < 6; r++) begin
            run_pass(10'($urandom), int'($urandom_range(0, 60)),
                     int'($urandom_range(8, 14)), -1, 1'b0, 0);
        end

        repeat (3) step();
        chk("writes_outstanding", wq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
